// File: rtl/mcu_sequencer.sv
// mcu_sequencer: gathers NUM_CH single-channel IDCT blocks into complete
// MCUs using two ping-pong buffers, delivers them over a valid/ready
// handshake and throttles the upstream word request while a buffer waits.
// Optional delivered-MCU statistics counter: define MCU_SEQ_STATS_EN.
module mcu_sequencer #(
  parameter int NUM_CH = 3,
  parameter int CHW    = $clog2(NUM_CH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid_in,
  input  logic [CHW-1:0]   blk_ch_in,
  input  logic [7:0]       blk_in [0:7][0:7],
  input  logic             req_in,
  output logic             request_out,
  output logic [7:0]       mcu_out [0:NUM_CH-1][0:7][0:7],
  output logic             mcu_valid,
  input  logic             mcu_ready,
  output logic             err_seq,
  output logic             err_ovf,
  output logic [15:0]      mcu_count
);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  buf_state_e     st_r   [0:1];
  buf_state_e     st_n_s [0:1];
  buf_state_e     wr_state_s;
  buf_state_e     oth_state_s;
  logic           wr_ptr_r, wr_ptr_n_s;
  logic           rd_ptr_r, rd_ptr_n_s;
  logic [CHW-1:0] fidx_r, fidx_n_s;
  logic           err_seq_r, err_seq_n_s;
  logic           err_ovf_r, err_ovf_n_s;
  logic           hs_s;
  logic           accept_s;
  logic           last_s;
  logic           hold_s;

  // Pixel storage is not reset; validity is tracked only by st_r.
  logic [7:0]     buf_r [0:1][0:NUM_CH-1][0:7][0:7];

  // Next-state logic for buffer states, pointers, fill index and sticky errors.
  always_comb begin
    st_n_s[0]   = st_r[0];
    st_n_s[1]   = st_r[1];
    wr_ptr_n_s  = wr_ptr_r;
    rd_ptr_n_s  = rd_ptr_r;
    fidx_n_s    = fidx_r;
    err_seq_n_s = err_seq_r;
    err_ovf_n_s = err_ovf_r;
    wr_state_s  = st_r[wr_ptr_r];
    oth_state_s = st_r[~wr_ptr_r];
    hs_s        = (st_r[rd_ptr_r] == BUF_FULL) && mcu_ready;
    last_s      = (fidx_r == CHW'(NUM_CH - 1));
    accept_s    = 1'b0;

    // A handshake can only target a FULL buffer and a write only a non-FULL
    // one, so both updates never touch the same buffer in one cycle.
    if (hs_s) begin
      st_n_s[rd_ptr_r] = BUF_EMPTY;
      rd_ptr_n_s       = ~rd_ptr_r;
    end else begin
      rd_ptr_n_s       = rd_ptr_r;
    end

    if (blk_valid_in) begin
      if (wr_state_s == BUF_FULL) begin
        err_ovf_n_s = 1'b1;
      end else if (blk_ch_in != fidx_r) begin
        err_seq_n_s = 1'b1;
      end else begin
        accept_s = 1'b1;
        if (last_s) begin
          st_n_s[wr_ptr_r] = BUF_FULL;
          fidx_n_s         = '0;
          wr_ptr_n_s       = ~wr_ptr_r;
        end else begin
          st_n_s[wr_ptr_r] = BUF_FILLING;
          fidx_n_s         = fidx_r + CHW'(1);
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r[0]   <= BUF_EMPTY;
      st_r[1]   <= BUF_EMPTY;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      fidx_r    <= '0;
      err_seq_r <= 1'b0;
      err_ovf_r <= 1'b0;
    end else begin
      st_r[0]   <= st_n_s[0];
      st_r[1]   <= st_n_s[1];
      wr_ptr_r  <= wr_ptr_n_s;
      rd_ptr_r  <= rd_ptr_n_s;
      fidx_r    <= fidx_n_s;
      err_seq_r <= err_seq_n_s;
      err_ovf_r <= err_ovf_n_s;
    end
  end

  // Store an accepted block into its channel slot of the write buffer.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          buf_r[wr_ptr_r][fidx_r][r][c] <= blk_in[r][c];
        end
      end
    end
  end

  // Present the read buffer; it only changes on a handshake, so it stays
  // stable while the consumer stalls.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          mcu_out[k][r][c] = buf_r[rd_ptr_r][k][r][c];
        end
      end
    end
  end

  // Stall upstream once the spare buffer is occupied and the other is pending.
  always_comb begin
    hold_s      = (oth_state_s == BUF_FULL) && (wr_state_s != BUF_EMPTY);
    request_out = req_in && !hold_s;
  end

  assign mcu_valid = (st_r[rd_ptr_r] == BUF_FULL);
  assign err_seq   = err_seq_r;
  assign err_ovf   = err_ovf_r;

`ifdef MCU_SEQ_STATS_EN
  logic [15:0] mcu_count_r;

  // Count delivered MCUs; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcu_count_r <= 16'd0;
    end else if (hs_s) begin
      mcu_count_r <= mcu_count_r + 16'd1;
    end else begin
      mcu_count_r <= mcu_count_r;
    end
  end

  assign mcu_count = mcu_count_r;
`else
  assign mcu_count = 16'd0;
`endif

endmodule
